// File: rtl/vic_video_pkg.sv
// Shared video types for the VIC-II output path: colour index, 4-bit RGB triple,
// the 16-entry C64 palette and the default output raster geometry.
package vic_video_pkg;

    localparam int LINE_PIXELS_DEF  = 384;
    localparam int OUT_H_TOTAL_DEF  = 504;
    localparam int OUT_HS_START_DEF = 400;
    localparam int OUT_HS_LEN_DEF   = 48;

    typedef logic [3:0] vic_color_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // C64 colours 0..15 reduced to 4 bits per channel, packed as {r,g,b}
    localparam rgb444_t VIC_PALETTE [16] = '{
        12'h000, 12'hFFF, 12'h833, 12'h6CC,
        12'h849, 12'h5A4, 12'h329, 12'hBC7,
        12'h852, 12'h530, 12'hB66, 12'h444,
        12'h777, 12'h9E8, 12'h76D, 12'hAAA
    };

endpackage

// File: rtl/vic_line_ram.sv
// Two-line colour-index buffer: one write port, one registered read port.
// Address is {line select, x}; no reset so it maps onto block RAM.
module vic_line_ram
    import vic_video_pkg::*;
#(
    parameter int XW = 9
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [XW:0]   i_waddr,
    input  vic_color_t    i_wdata,
    input  logic [XW:0]   i_raddr,
    output vic_color_t    o_rdata
);

    vic_color_t r_mem [0:(2**(XW+1))-1];
    vic_color_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vic_scan_doubler.sv
// Scan doubler: stores one 15 kHz VIC source line and plays it out twice at 31 kHz,
// with palette lookup and a fixed two-clock pixel pipeline.
module vic_scan_doubler
    import vic_video_pkg::*;
#(
    parameter int LINE_PIXELS  = LINE_PIXELS_DEF,
    parameter int OUT_H_TOTAL  = OUT_H_TOTAL_DEF,
    parameter int OUT_HS_START = OUT_HS_START_DEF,
    parameter int OUT_HS_LEN   = OUT_HS_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] in_color,
    input  logic       in_hsync,
    input  logic       in_vsync,
    output logic       out_hsync,
    output logic       out_vsync,
    output logic       out_de,
    output logic [3:0] out_red,
    output logic [3:0] out_green,
    output logic [3:0] out_blue,
    output logic       overflow
);

    localparam int XW = $clog2(LINE_PIXELS + 1);
    localparam int HW = $clog2(OUT_H_TOTAL);

    localparam logic [XW-1:0] X_LIMIT  = XW'(LINE_PIXELS);
    localparam logic [HW-1:0] H_ACTIVE = HW'(LINE_PIXELS);
    localparam logic [HW-1:0] H_LAST   = HW'(OUT_H_TOTAL - 1);
    localparam logic [HW-1:0] HS_BEGIN = HW'(OUT_HS_START);
    localparam logic [HW-1:0] HS_END   = HW'(OUT_HS_START + OUT_HS_LEN);

    logic          r_hsyncQ;
    logic          r_wrSel;
    logic [XW-1:0] r_wrX;
    logic          r_primed;
    logic          r_overflow;
    logic [HW-1:0] r_hcnt;
    logic          r_phase;
    logic          r_vsLine;
    logic          r_de1, r_hs1, r_vs1;
    logic          r_de2, r_hs2, r_vs2;
    rgb444_t       r_rgb;

    logic          w_hsEdge;
    logic          w_we;
    logic          w_wrSelNow;
    logic [XW-1:0] w_wrXNow;
    logic [XW-1:0] w_rdX;
    logic          w_deRaw;
    logic          w_hsRaw;
    logic          w_vsRaw;
    vic_color_t    w_ramData;

    assign w_hsEdge = in_hsync & ~r_hsyncQ;

    // A pixel arriving on the sync edge already belongs to the new line at x=0
    always_comb begin
        w_wrSelNow = w_hsEdge ? ~r_wrSel : r_wrSel;
        w_wrXNow   = w_hsEdge ? '0 : r_wrX;
        w_we       = in_valid & (w_hsEdge | (r_wrX < X_LIMIT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsyncQ   <= 1'b0;
            r_wrSel    <= 1'b0;
            r_wrX      <= '0;
            r_primed   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_hsyncQ <= in_hsync;
            if (w_hsEdge) begin
                r_wrSel  <= ~r_wrSel;
                r_wrX    <= in_valid ? XW'(1) : '0;
                r_primed <= 1'b1;
            end else if (in_valid) begin
                if (r_wrX < X_LIMIT) begin
                    r_wrX <= r_wrX + XW'(1);
                end else begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // A new source line restarts the output pair; otherwise the line just repeats
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hcnt   <= '0;
            r_phase  <= 1'b0;
            r_vsLine <= 1'b0;
        end else begin
            if (w_hsEdge) begin
                r_hcnt  <= '0;
                r_phase <= 1'b0;
            end else if (r_hcnt == H_LAST) begin
                r_hcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_hcnt <= r_hcnt + HW'(1);
            end
            if (r_hcnt == '0) begin
                r_vsLine <= in_vsync;
            end
        end
    end

    always_comb begin
        w_rdX   = XW'(r_hcnt);
        w_deRaw = r_primed & (r_hcnt < H_ACTIVE);
        w_hsRaw = (r_hcnt >= HS_BEGIN) && (r_hcnt < HS_END);
        w_vsRaw = (r_hcnt == '0) ? in_vsync : r_vsLine;
    end

    vic_line_ram #(
        .XW (XW)
    ) u_lineRam (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr ({w_wrSelNow, w_wrXNow}),
        .i_wdata (in_color),
        .i_raddr ({~r_wrSel, w_rdX}),
        .o_rdata (w_ramData)
    );

    // Stage 1 rides alongside the RAM read; stage 2 registers the palette result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_de1 <= 1'b0;
            r_hs1 <= 1'b0;
            r_vs1 <= 1'b0;
            r_de2 <= 1'b0;
            r_hs2 <= 1'b0;
            r_vs2 <= 1'b0;
            r_rgb <= '0;
        end else begin
            r_de1 <= w_deRaw;
            r_hs1 <= w_hsRaw;
            r_vs1 <= w_vsRaw;
            r_de2 <= r_de1;
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            r_rgb <= r_de1 ? VIC_PALETTE[w_ramData] : '0;
        end
    end

    assign out_hsync = r_hs2;
    assign out_vsync = r_vs2;
    assign out_de    = r_de2;
    assign out_red   = r_rgb.r;
    assign out_green = r_rgb.g;
    assign out_blue  = r_rgb.b;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_vic_scan_doubler.sv
// Directed bench for vic_scan_doubler: sync timing, line doubling, overflow,
// pixel-on-edge, line repeat, frame sync and asynchronous reset.
module tb_vic_scan_doubler;

    localparam int LP  = 384;
    localparam int HT  = 504;
    localparam int HS0 = 400;
    localparam int HSL = 48;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_color;
    logic       in_hsync;
    logic       in_vsync;
    logic       out_hsync;
    logic       out_vsync;
    logic       out_de;
    logic [3:0] out_red;
    logic [3:0] out_green;
    logic [3:0] out_blue;
    logic       overflow;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          tbWrSel;
    logic [3:0]  expBuf [2][LP];
    logic [11:0] pix2Seen;
    wire  [15:0] allOut = {out_hsync, out_vsync, out_de, out_red, out_green, out_blue, overflow};

    always #5 clk = ~clk;

    vic_scan_doubler dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_color  (in_color),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .out_hsync (out_hsync),
        .out_vsync (out_vsync),
        .out_de    (out_de),
        .out_red   (out_red),
        .out_green (out_green),
        .out_blue  (out_blue),
        .overflow  (overflow)
    );

    function automatic logic [11:0] palRgb(input logic [3:0] c);
        case (c)
            4'd0:  return 12'h000;
            4'd1:  return 12'hFFF;
            4'd2:  return 12'h833;
            4'd3:  return 12'h6CC;
            4'd4:  return 12'h849;
            4'd5:  return 12'h5A4;
            4'd6:  return 12'h329;
            4'd7:  return 12'hBC7;
            4'd8:  return 12'h852;
            4'd9:  return 12'h530;
            4'd10: return 12'hB66;
            4'd11: return 12'h444;
            4'd12: return 12'h777;
            4'd13: return 12'h9E8;
            4'd14: return 12'h76D;
            default: return 12'hAAA;
        endcase
    endfunction

    function automatic logic [3:0] patColor(input int mode, input int x);
        case (mode)
            0:       return 4'(x % 16);
            1:       return 4'((x * 7 + 1) % 16);
            default: return 4'((x * 5) % 16);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] color, input logic hsync);
        in_valid = valid;
        in_color = color;
        in_hsync = hsync;
        @(negedge clk);
    endtask

    task automatic sendLine(input int startX, input int count, input int mode);
        int         x;
        logic [3:0] c;
        for (int i = 0; i < count; i++) begin
            x = startX + i;
            c = patColor(mode, x);
            applyStimulus(1'b1, c, 1'b0);
            if (x < LP) expBuf[tbWrSel][x] = c;
            applyStimulus(1'b0, 4'd0, 1'b0);
        end
    endtask

    // Returns two negedges after the sync pulse was driven; pixel 0 appears one negedge later
    task automatic hsPulse(input logic valid, input logic [3:0] color);
        tbWrSel = 1 - tbWrSel;
        if (valid) expBuf[tbWrSel][0] = color;
        applyStimulus(valid, color, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0);
    endtask

    task automatic checkLine(input string tag, input logic expVs);
        int          rs;
        logic        act;
        logic        hsExp;
        logic [14:0] obs;
        logic [14:0] exp;
        rs = 1 - tbWrSel;
        for (int h = 0; h < HT; h++) begin
            act   = (h < LP);
            hsExp = (h >= HS0) && (h < HS0 + HSL);
            exp   = {act, hsExp, expVs, act ? palRgb(expBuf[rs][h]) : 12'h000};
            obs   = {out_de, out_hsync, out_vsync, out_red, out_green, out_blue};
            if (h == 2) pix2Seen = {out_red, out_green, out_blue};
            checkOutput($sformatf("%s h=%0d", tag, h), 32'(obs), 32'(exp));
            applyStimulus(1'b0, 4'd0, 1'b0);
        end
    endtask

    initial begin
        int deHigh;
        int hsHigh;
        int rises;
        int rise1;
        int rise2;
        logic prevHs;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_color = 4'd0;
        in_hsync = 1'b0;
        in_vsync = 1'b0;
        tbWrSel  = 0;
        repeat (3) @(negedge clk);
        checkOutput("t1_reset_outputs", 32'(allOut), 32'h0);
        reset = 1'b0;

        // Idle raster: no picture, hsync 48 of every 504 clocks
        deHigh = 0; hsHigh = 0; rises = 0; rise1 = 0; rise2 = 0; prevHs = 1'b0;
        for (int i = 1; i <= 2 * HT; i++) begin
            applyStimulus(1'b0, 4'd0, 1'b0);
            if (out_de) deHigh++;
            if (out_hsync) hsHigh++;
            if (out_hsync && !prevHs) begin
                rises++;
                if (rises == 1) rise1 = i;
                if (rises == 2) rise2 = i;
            end
            prevHs = out_hsync;
        end
        checkOutput("t1_de_high_cycles", 32'(deHigh), 32'd0);
        checkOutput("t1_hs_high_cycles", 32'(hsHigh), 32'd96);
        checkOutput("t1_hs_rises", 32'(rises), 32'd2);
        checkOutput("t1_hs_period", 32'(rise2 - rise1), 32'd504);

        // Full line x%16, then doubled output
        sendLine(0, LP, 0);
        hsPulse(1'b0, 4'd0);
        checkOutput("t2_de_before_latency", 32'(out_de), 32'd0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkLine("t2_line1", 1'b0);
        checkLine("t2_line2", 1'b0);
        checkOutput("t2_pix2", 32'(pix2Seen), 32'h833);

        // 400 pixels: overflow on the 385th, buffer keeps 0..383
        sendLine(0, LP, 1);
        checkOutput("t3_overflow_at_384", 32'(overflow), 32'd0);
        sendLine(LP, 1, 1);
        checkOutput("t3_overflow_at_385", 32'(overflow), 32'd1);
        sendLine(LP + 1, 15, 1);
        hsPulse(1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkLine("t3_line", 1'b0);
        checkOutput("t3_overflow_sticky", 32'(overflow), 32'd1);

        // Pixel presented on the sync edge lands at x=0
        hsPulse(1'b1, 4'd6);
        sendLine(1, LP - 1, 2);
        hsPulse(1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("t4_pix0_rgb", 32'({out_red, out_green, out_blue}), 32'h329);
        checkOutput("t4_pix0_de_hs", 32'({out_de, out_hsync}), 32'h2);
        checkLine("t4_line", 1'b0);

        // No new source line: same buffer keeps repeating
        checkLine("t5_rep1", 1'b0);
        checkLine("t5_rep2", 1'b0);
        checkLine("t5_rep3", 1'b0);
        checkOutput("t5_overflow_still", 32'(overflow), 32'd1);

        // Frame sync across two source lines -> four output lines
        in_vsync = 1'b1;
        hsPulse(1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkLine("t6_vs_l1", 1'b1);
        checkLine("t6_vs_l2", 1'b1);
        hsPulse(1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkLine("t6_vs_l3", 1'b1);
        checkLine("t6_vs_l4", 1'b1);
        in_vsync = 1'b0;
        hsPulse(1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkLine("t6_vs_l5", 1'b0);

        // Reset in the middle of an active line
        hsPulse(1'b0, 4'd0);
        repeat (50) applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("t6_de_before_reset", 32'(out_de), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("t6_reset_async", 32'(allOut), 32'h0);
        @(negedge clk);
        checkOutput("t6_reset_next_edge", 32'(allOut), 32'h0);
        reset   = 1'b0;
        tbWrSel = 0;
        deHigh  = 0;
        repeat (HT) begin
            applyStimulus(1'b0, 4'd0, 1'b0);
            if (out_de) deHigh++;
        end
        checkOutput("t6_unprimed_de", 32'(deHigh), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
